// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial-adder FSM encoding and default width.
package arith_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned STATE_W   = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage : arith_pkg

// File: rtl/fulladder.sv
// Single-bit full-adder cell used as the bit-slice of the serial adder.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule : fulladder

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first,
// with a start/done handshake and results held until the next accepted start.
module serial_adder
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fa_s;
  logic               fa_cout;

  fulladder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Next-state and datapath update; busy/done are registered from the next state.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        // Last bit: carry_q is the carry into the MSB.
        if (cnt_q == LAST_IDX) begin
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver queues expected results, monitor
// pops and compares on every done pulse.
module tb_serial_adder;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  res_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   done_cnt  = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      res_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        check("sb_sum",  32'(sum),  32'(e.sum));
        check("sb_cout", 32'(cout), 32'(e.cout));
        check("sb_ovf",  32'(ovf),  32'(e.ovf));
      end
    end
  end

  // One operation: accept, optionally disturb operands, time busy/done, check hold.
  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic [W-1:0] es, input logic ec,
                        input logic eo, input bit disturb);
    int cyc;
    int busy_cycles;
    a = va; b = vb; cin = vc; start = 1'b1;
    exp_q.push_back('{sum: es, cout: ec, ovf: eo});
    tick();
    start = 1'b0;
    if (disturb) begin
      a = ~va; b = va ^ 8'h5A; cin = ~vc;
    end
    cyc = 0;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
      if (busy === 1'b1) busy_cycles++;
    end
    check({name, "_done_latency"}, 32'(cyc), 32'(W));
    check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(W + 1));
    tick();
    tick();
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    check({name, "_idle_done"}, 32'(done), 32'd0);
    check({name, "_held_sum"}, 32'(sum), 32'(es));
    check({name, "_held_cout"}, 32'(cout), 32'(ec));
    check({name, "_held_ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    int base;
    int t1;
    int t2;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sum",  32'(sum),  32'd0);
    check("idle_done_cnt", 32'(done_cnt), 32'd0);

    run_op("basic",   8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
    run_op("carry",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("negwrap", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    run_op("cinonly", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);

    // start pulses in RUN and DONE must be ignored.
    base = done_cnt;
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    exp_q.push_back('{sum: 8'h30, cout: 1'b0, ovf: 1'b0});
    tick();
    start = 1'b0;
    a = 8'hAA; b = 8'h55;
    for (int i = 1; i <= 12; i++) begin
      start = (i == 3 || i == 9);
      tick();
    end
    start = 1'b0;
    check("ignore_done_pulses", 32'(done_cnt - base), 32'd1);
    check("ignore_sum", 32'(sum), 32'h30);
    check("ignore_busy", 32'(busy), 32'd0);

    // start held high across two operations.
    base = done_cnt;
    t1 = -1; t2 = -1;
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    exp_q.push_back('{sum: 8'h03, cout: 1'b0, ovf: 1'b0});
    exp_q.push_back('{sum: 8'h80, cout: 1'b0, ovf: 1'b1});
    tick();
    a = 8'h7F; b = 8'h01;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      tick();
      if (cyc == W + 2) start = 1'b0;
      if (done === 1'b1) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    check("b2b_done_pulses", 32'(done_cnt - base), 32'd2);
    check("b2b_first_done", 32'(t1), 32'(W));
    check("b2b_spacing", 32'(t2 - t1), 32'(W + 2));
    check("b2b_final_sum", 32'(sum), 32'h80);

    // Reset at RUN cnt=4 discards the operation.
    base = done_cnt;
    a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum",  32'(sum),  32'd0);
    check("midrst_done", 32'(done), 32'd0);
    repeat (12) tick();
    check("midrst_no_done", 32'(done_cnt - base), 32'd0);
    run_op("postrst", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_adder
